// File: rtl/scatter_wr_engine_pkg.sv
// Shared encodings and helpers for the scatter write engine.
// lane_swap is only used when SCATTER_WR_BYTESWAP_EN is defined.
package scatter_wr_engine_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GET_ADDR = 3'd1;
    localparam logic [2:0] ST_ADDR     = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    localparam logic [2:0] SIZE_64B   = 3'b110;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] OKAY       = 2'b00;

    localparam int LANE_W  = 64;
    localparam int SWAP_DW = 512;

    // Reverse the order of the 64-bit lanes so lane0 lands in the top lane.
    function automatic logic [SWAP_DW-1:0] lane_swap(input logic [SWAP_DW-1:0] d);
        logic [SWAP_DW-1:0] r;
        r = '0;
        for (int i = 0; i < SWAP_DW / LANE_W; i++) begin
            r[i*LANE_W +: LANE_W] = d[(SWAP_DW/LANE_W - 1 - i)*LANE_W +: LANE_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/scatter_wr_engine_if.sv
// gen_m0 write-master bus: address request, write-data beats and B response.
interface scatter_wr_engine_if #(
    parameter int AW   = 64,
    parameter int DW   = 512,
    parameter int MIDW = 1
);
    logic [AW-1:0]   maddr;
    logic [7:0]      mlen;
    logic [MIDW-1:0] mid;
    logic [2:0]      msize;
    logic [1:0]      mburst;
    logic [3:0]      mcache;
    logic [2:0]      mprot;
    logic            mlock;
    logic            mwrite;
    logic            saccept;
    logic [DW-1:0]   mdata;
    logic [DW/8-1:0] mwstrb;
    logic            mwvalid;
    logic            swready;
    logic            mwlast;
    logic            sbvalid;
    logic [1:0]      sbresp;
    logic            mbready;

    modport master (
        output maddr, mlen, mid, msize, mburst, mcache, mprot, mlock, mwrite,
        output mdata, mwstrb, mwvalid, mwlast, mbready,
        input  saccept, swready, sbvalid, sbresp
    );

    modport slave (
        input  maddr, mlen, mid, msize, mburst, mcache, mprot, mlock, mwrite,
        input  mdata, mwstrb, mwvalid, mwlast, mbready,
        output saccept, swready, sbvalid, sbresp
    );
endinterface

// File: rtl/scatter_wr_engine_addr_gen.sv
// Block address source: contiguous base+offset counter (mode 0) or address-stream pop (mode 1).
// addr_vld_o is a single-cycle strobe taken by the engine while it waits in GET_ADDR.
module scatter_wr_addr_gen
    import scatter_wr_engine_pkg::*;
#(
    parameter int AXI_AW = 64
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              clear_i,
    input  logic              active_i,
    input  logic              stall_i,
    input  logic              mode_i,
    input  logic [AXI_AW-1:0] base_i,
    input  logic [31:0]       block_size_i,
    input  logic              s_addr_valid_i,
    output logic              s_addr_ready_o,
    input  logic [AXI_AW-1:0] s_addr_data_i,
    output logic              addr_vld_o,
    output logic [AXI_AW-1:0] addr_o
);

    logic [AXI_AW-1:0] offset_q, offset_d;
    logic              take;

    assign take           = active_i && !stall_i;
    assign s_addr_ready_o = take && mode_i;
    assign addr_vld_o     = mode_i ? (s_addr_valid_i && s_addr_ready_o) : take;
    assign addr_o         = mode_i ? s_addr_data_i : (base_i + offset_q);

    // Running offset replaces blk_cnt*block_size so no multiplier is needed.
    always_comb begin
        offset_d = offset_q;
        if (clear_i) begin
            offset_d = '0;
        end else if (addr_vld_o && !mode_i) begin
            offset_d = offset_q + {{(AXI_AW-32){1'b0}}, block_size_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end

endmodule

// File: rtl/scatter_wr_engine.sv
// Scatter write engine: writes a 512-bit beat stream to host memory as block_num bursts of block_size bytes.
// Define SCATTER_WR_BYTESWAP_EN to reverse the 64-bit lanes of every beat on its way to gen_m0_mdata.
module scatter_wr_engine
    import scatter_wr_engine_pkg::*;
#(
    parameter int                   AXI_DW    = 512,
    parameter int                   AXI_AW    = 64,
    parameter int                   AXI_MIDW  = 1,
    parameter logic [AXI_MIDW-1:0]  AXI_WID   = '0,
    parameter int                   MAX_OUTST = 8
) (
    input  logic              axi_clk,
    input  logic              axi_rstn,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [AXI_AW-1:0] i_wb_addr,
    input  logic [31:0]       i_block_size,
    input  logic [31:0]       i_block_num,
    input  logic              s_addr_valid,
    output logic              s_addr_ready,
    input  logic [AXI_AW-1:0] s_addr_data,
    input  logic              s_data_valid,
    output logic              s_data_ready,
    input  logic [AXI_DW-1:0] s_data_data,
    scatter_wr_engine_if.master gen_m0,
    output logic              o_done,
    output logic              o_error,
    output logic              o_busy
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);

    logic [2:0]        state_q, state_d;
    logic [31:0]       blk_cnt_q, blk_cnt_d;
    logic [31:0]       resp_cnt_q, resp_cnt_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [7:0]        beat_q, beat_d;
    logic [AXI_AW-1:0] maddr_q, maddr_d;
    logic [7:0]        mlen_q, mlen_d;
    logic              mwrite_q, mwrite_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              mode_q;
    logic [AXI_AW-1:0] base_q;
    logic [31:0]       size_q;
    logic [31:0]       num_q;

    logic              start_ok, in_data, w_hs, last_hs, b_spur, b_ok;
    logic              addr_vld;
    logic [AXI_AW-1:0] addr;
    logic [AXI_DW-1:0] beat_data;

    assign start_ok = i_start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign in_data  = (state_q == ST_DATA);
    assign w_hs     = in_data && s_data_valid && gen_m0.swready;
    assign last_hs  = w_hs && (beat_q == mlen_q);
    assign b_spur   = gen_m0.sbvalid && (outst_q == '0);
    assign b_ok     = gen_m0.sbvalid && (outst_q != '0);

    scatter_wr_addr_gen #(
        .AXI_AW (AXI_AW)
    ) u_addr_gen (
        .clk_i          (axi_clk),
        .rstn_i         (axi_rstn),
        .clear_i        (start_ok),
        .active_i       (state_q == ST_GET_ADDR),
        .stall_i        (outst_q == OUTST_MAX),
        .mode_i         (mode_q),
        .base_i         (base_q),
        .block_size_i   (size_q),
        .s_addr_valid_i (s_addr_valid),
        .s_addr_ready_o (s_addr_ready),
        .s_addr_data_i  (s_addr_data),
        .addr_vld_o     (addr_vld),
        .addr_o         (addr)
    );

    always_comb begin
        state_d    = state_q;
        blk_cnt_d  = blk_cnt_q;
        resp_cnt_d = resp_cnt_q;
        outst_d    = outst_q;
        beat_d     = beat_q;
        maddr_d    = maddr_q;
        mlen_d     = mlen_q;
        mwrite_d   = mwrite_q;
        done_d     = done_q;
        error_d    = error_q;

        // B responses are tracked in every state so late or spurious ones still flag an error.
        if (b_spur) begin
            error_d = 1'b1;
        end
        if (b_ok) begin
            resp_cnt_d = resp_cnt_q + 32'd1;
            if (gen_m0.sbresp != OKAY) begin
                error_d = 1'b1;
            end
        end
        if (last_hs && !b_ok) begin
            outst_d = outst_q + OW'(1);
        end else if (!last_hs && b_ok) begin
            outst_d = outst_q - OW'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d    = ST_GET_ADDR;
                    blk_cnt_d  = '0;
                    resp_cnt_d = '0;
                    outst_d    = '0;
                    beat_d     = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                end
            end
            ST_GET_ADDR: begin
                if (addr_vld) begin
                    maddr_d  = addr;
                    mlen_d   = size_q[13:6] - 8'd1;
                    mwrite_d = 1'b1;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (gen_m0.saccept) begin
                    mwrite_d = 1'b0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    if (beat_q == mlen_q) begin
                        beat_d    = '0;
                        blk_cnt_d = blk_cnt_q + 32'd1;
                        state_d   = (blk_cnt_q + 32'd1 < num_q) ? ST_GET_ADDR : ST_DRAIN;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (outst_q == '0 && resp_cnt_q == num_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_rstn) begin
            state_q    <= ST_IDLE;
            blk_cnt_q  <= '0;
            resp_cnt_q <= '0;
            outst_q    <= '0;
            beat_q     <= '0;
            maddr_q    <= '0;
            mlen_q     <= '0;
            mwrite_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_cnt_q  <= blk_cnt_d;
            resp_cnt_q <= resp_cnt_d;
            outst_q    <= outst_d;
            beat_q     <= beat_d;
            maddr_q    <= maddr_d;
            mlen_q     <= mlen_d;
            mwrite_q   <= mwrite_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Transfer parameters are only meaningful after a start, so they carry no reset.
    always_ff @(posedge axi_clk) begin
        if (start_ok) begin
            mode_q <= i_mode;
            base_q <= i_wb_addr;
            size_q <= i_block_size;
            num_q  <= i_block_num;
        end
    end

`ifdef SCATTER_WR_BYTESWAP_EN
    assign beat_data = lane_swap(s_data_data);
`else
    assign beat_data = s_data_data;
`endif

    assign s_data_ready   = in_data && gen_m0.swready;
    assign gen_m0.mwvalid = in_data && s_data_valid;
    assign gen_m0.mdata   = in_data ? beat_data : '0;
    assign gen_m0.mwlast  = in_data && (beat_q == mlen_q);
    assign gen_m0.mwstrb  = '1;
    assign gen_m0.mbready = 1'b1;
    assign gen_m0.maddr   = maddr_q;
    assign gen_m0.mlen    = mlen_q;
    assign gen_m0.mwrite  = mwrite_q;
    assign gen_m0.mid     = AXI_WID;
    assign gen_m0.msize   = SIZE_64B;
    assign gen_m0.mburst  = BURST_INCR;
    assign gen_m0.mcache  = 4'b0000;
    assign gen_m0.mprot   = 3'b000;
    assign gen_m0.mlock   = 1'b0;

    assign o_done  = done_q;
    assign o_error = error_q;
    assign o_busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_scatter_wr_engine.sv
// Directed bench for scatter_wr_engine: contiguous/stream addressing, throttling, B back-pressure,
// error response, mid-burst reset and lane ordering of the write data.
module tb_scatter_wr_engine;

    logic          axi_clk;
    logic          axi_rstn;
    logic          i_start;
    logic          i_mode;
    logic [63:0]   i_wb_addr;
    logic [31:0]   i_block_size;
    logic [31:0]   i_block_num;
    logic          s_addr_valid;
    logic          s_addr_ready;
    logic [63:0]   s_addr_data;
    logic          s_data_valid;
    logic          s_data_ready;
    logic [511:0]  s_data_data;
    logic          o_done;
    logic          o_error;
    logic          o_busy;

    scatter_wr_engine_if #(.AW(64), .DW(512), .MIDW(1)) gen_m0 ();

    scatter_wr_engine #(
        .AXI_DW    (512),
        .AXI_AW    (64),
        .AXI_MIDW  (1),
        .AXI_WID   (1'b0),
        .MAX_OUTST (2)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_rstn     (axi_rstn),
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_wb_addr    (i_wb_addr),
        .i_block_size (i_block_size),
        .i_block_num  (i_block_num),
        .s_addr_valid (s_addr_valid),
        .s_addr_ready (s_addr_ready),
        .s_addr_data  (s_addr_data),
        .s_data_valid (s_data_valid),
        .s_data_ready (s_data_ready),
        .s_data_data  (s_data_data),
        .gen_m0       (gen_m0),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_busy       (o_busy)
    );

    initial begin
        axi_clk = 1'b0;
        forever #2 axi_clk = ~axi_clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Payload beat k: lane i holds {k, 24'h0, 10+i}, so lane0 of beat 0 is exactly 0xA.
    function automatic logic [511:0] src_beat(input int k);
        logic [511:0] r;
        for (int i = 0; i < 8; i++) r[i*64 +: 64] = {32'(k), 24'h0, 8'(10 + i)};
        return r;
    endfunction

    function automatic logic [511:0] exp_mdata(input int k);
        logic [511:0] r;
        for (int j = 0; j < 8; j++) begin
`ifdef SCATTER_WR_BYTESWAP_EN
            r[j*64 +: 64] = {32'(k), 24'h0, 8'(17 - j)};
`else
            r[j*64 +: 64] = {32'(k), 24'h0, 8'(10 + j)};
`endif
        end
        return r;
    endfunction

    bit          acc_rand, wr_rand, dv_rand, b_hold;
    int          err_blk;
    logic        tb_clr;
    logic [7:0]  exp_mlen;
    int          src_total;
    logic [63:0] exp_addr_a [8];
    logic [63:0] stream_a [8];
    int          n_stream;

    int           src_idx, pop_idx, n_beats, n_bursts, n_acc, n_pops, n_b, pend_b, b_sent, beat_in;
    logic         aw_wait;
    logic [63:0]  aw_held;
    logic [511:0] first_mdata;
    logic         d_hs, a_hs;

    // Slave/source model: observe at negedge, drive new values 1 time unit after posedge.
    initial begin : slave_model
        gen_m0.saccept = 1'b0;
        gen_m0.swready = 1'b0;
        gen_m0.sbvalid = 1'b0;
        gen_m0.sbresp  = 2'b00;
        s_data_valid   = 1'b0;
        s_data_data    = '0;
        s_addr_valid   = 1'b0;
        s_addr_data    = '0;
        forever begin
            @(negedge axi_clk);
            d_hs = 1'b0;
            a_hs = 1'b0;
            if (!axi_rstn || tb_clr) begin
                src_idx = 0; pop_idx = 0; n_beats = 0; n_bursts = 0; n_acc = 0; n_pops = 0;
                n_b = 0; pend_b = 0; b_sent = 0; beat_in = 0; aw_wait = 1'b0; aw_held = '0;
                first_mdata = '0;
            end else begin
                if (aw_wait) begin
                    check_eq("mwrite_held", gen_m0.mwrite, 1'b1);
                    check_eq("maddr_held", gen_m0.maddr, aw_held);
                end
                aw_wait = gen_m0.mwrite && !gen_m0.saccept;
                aw_held = gen_m0.maddr;
                if (gen_m0.mwrite && gen_m0.saccept) begin
                    check_eq("maddr", gen_m0.maddr, exp_addr_a[n_acc % 8]);
                    check_eq("mlen", gen_m0.mlen, exp_mlen);
                    n_acc++;
                end
                if (gen_m0.mwvalid && gen_m0.swready) begin
                    check_eq("mdata", gen_m0.mdata, exp_mdata(n_beats));
                    check_eq("mwlast", gen_m0.mwlast, beat_in == int'(exp_mlen));
                    if (n_beats == 0) first_mdata = gen_m0.mdata;
                    n_beats++;
                    if (beat_in == int'(exp_mlen)) begin
                        beat_in = 0;
                        n_bursts++;
                        pend_b++;
                    end else begin
                        beat_in++;
                    end
                end
                d_hs = s_data_valid && s_data_ready;
                a_hs = s_addr_valid && s_addr_ready;
                if (a_hs) n_pops++;
                if (gen_m0.sbvalid) n_b++;
            end
            @(posedge axi_clk);
            #1;
            if (d_hs) src_idx++;
            if (a_hs) pop_idx++;
            gen_m0.saccept = acc_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            gen_m0.swready = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data_valid   = (src_idx < src_total) && (dv_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            s_data_data    = src_beat(src_idx);
            s_addr_valid   = (pop_idx < n_stream);
            s_addr_data    = stream_a[pop_idx % 8];
            if (pend_b > 0 && !b_hold) begin
                gen_m0.sbvalid = 1'b1;
                gen_m0.sbresp  = (b_sent == err_blk) ? 2'b10 : 2'b00;
                pend_b--;
                b_sent++;
            end else begin
                gen_m0.sbvalid = 1'b0;
                gen_m0.sbresp  = 2'b00;
            end
        end
    end

    task automatic start_run(input logic mode, input logic [63:0] base, input int size, input int num);
        exp_mlen  = 8'(size / 64 - 1);
        src_total = num * (size / 64);
        for (int i = 0; i < 8; i++) exp_addr_a[i] = mode ? stream_a[i] : base + 64'(i) * 64'(size);
        @(posedge axi_clk);
        #1;
        i_mode       = mode;
        i_wb_addr    = base;
        i_block_size = 32'(size);
        i_block_num  = 32'(num);
        i_start      = 1'b1;
        tb_clr       = 1'b1;
        @(posedge axi_clk);
        #1;
        i_start = 1'b0;
        tb_clr  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!o_done && n < budget) begin
            @(negedge axi_clk);
            n++;
        end
        check_eq({tag, "_done"}, o_done, 1'b1);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_mwrite"}, gen_m0.mwrite, 1'b0);
        check_eq({tag, "_mwvalid"}, gen_m0.mwvalid, 1'b0);
        check_eq({tag, "_mwlast"}, gen_m0.mwlast, 1'b0);
        check_eq({tag, "_maddr"}, gen_m0.maddr, 64'h0);
        check_eq({tag, "_mlen"}, gen_m0.mlen, 8'h0);
        check_eq({tag, "_mdata"}, gen_m0.mdata, 512'h0);
        check_eq({tag, "_s_addr_ready"}, s_addr_ready, 1'b0);
        check_eq({tag, "_s_data_ready"}, s_data_ready, 1'b0);
        check_eq({tag, "_done"}, o_done, 1'b0);
        check_eq({tag, "_error"}, o_error, 1'b0);
        check_eq({tag, "_busy"}, o_busy, 1'b0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : main
        int n;
        axi_rstn = 1'b0; i_start = 1'b0; i_mode = 1'b0; i_wb_addr = '0;
        i_block_size = '0; i_block_num = '0; tb_clr = 1'b0;
        acc_rand = 0; wr_rand = 0; dv_rand = 0; b_hold = 0; err_blk = -1;
        exp_mlen = '0; src_total = 0; n_stream = 2;
        for (int i = 0; i < 8; i++) begin
            stream_a[i]   = '0;
            exp_addr_a[i] = '0;
        end
        stream_a[0] = 64'h8000;
        stream_a[1] = 64'h40;
        repeat (3) @(posedge axi_clk);
        @(negedge axi_clk);
        check_idle("rst");
        check_eq("rst_mid", gen_m0.mid, 1'b0);
        check_eq("rst_mwstrb", gen_m0.mwstrb, {64{1'b1}});
        @(posedge axi_clk);
        #1 axi_rstn = 1'b1;

        // T1: contiguous, plus a start pulse while busy that must be ignored
        start_run(1'b0, 64'h1000, 4096, 3);
        repeat (20) @(posedge axi_clk);
        #1;
        check_eq("t1_busy", o_busy, 1'b1);
        i_block_num = 32'd1;
        i_start     = 1'b1;
        @(posedge axi_clk);
        #1 i_start = 1'b0;
        wait_done("t1", 3000);
        check_eq("t1_bursts", n_bursts, 3);
        check_eq("t1_beats", n_beats, 192);
        check_eq("t1_no_pops", n_pops, 0);
        check_eq("t1_error", o_error, 1'b0);
        check_eq("t1_idle", o_busy, 1'b0);
`ifdef SCATTER_WR_BYTESWAP_EN
        check_eq("t7_lane0_top", first_mdata[511:448], 64'hA);
        check_eq("t7_lane7_bottom", first_mdata[63:0], 64'h11);
`else
        check_eq("t7_lane0_bottom", first_mdata[63:0], 64'hA);
        check_eq("t7_lane7_top", first_mdata[511:448], 64'h11);
`endif

        // T2: stream addresses, single-beat bursts
        start_run(1'b1, 64'h0, 64, 2);
        wait_done("t2", 500);
        check_eq("t2_pops", n_pops, 2);
        check_eq("t2_bursts", n_bursts, 2);
        check_eq("t2_beats", n_beats, 2);

        // T3: random throttling on every handshake
        acc_rand = 1; wr_rand = 1; dv_rand = 1;
        start_run(1'b0, 64'h10000, 256, 5);
        wait_done("t3", 3000);
        check_eq("t3_bursts", n_bursts, 5);
        check_eq("t3_beats", n_beats, 20);
        check_eq("t3_acc", n_acc, 5);
        acc_rand = 0; wr_rand = 0; dv_rand = 0;

        // T4: B withheld, MAX_OUTST=2 limits bursts in flight
        b_hold = 1;
        start_run(1'b0, 64'h200, 64, 4);
        repeat (40) @(negedge axi_clk);
        check_eq("t4_stall_bursts", n_bursts, 2);
        check_eq("t4_stall_mwrite", gen_m0.mwrite, 1'b0);
        check_eq("t4_stall_busy", o_busy, 1'b1);
        check_eq("t4_stall_done", o_done, 1'b0);
        b_hold = 0;
        wait_done("t4", 500);
        check_eq("t4_bursts", n_bursts, 4);
        check_eq("t4_resps", n_b, 4);

        // T5: error response on block 1
        err_blk = 1;
        start_run(1'b0, 64'h3000, 128, 3);
        wait_done("t5", 500);
        check_eq("t5_error", o_error, 1'b1);
        check_eq("t5_bursts", n_bursts, 3);
        err_blk = -1;

        // T6: reset in the middle of a burst, then a clean run
        start_run(1'b0, 64'h100000, 4096, 2);
        n = 0;
        while (n_beats < 10 && n < 300) begin
            @(negedge axi_clk);
            n++;
        end
        check_eq("t6_reached_data", n_beats >= 10, 1'b1);
        @(posedge axi_clk);
        #1 axi_rstn = 1'b0;
        @(posedge axi_clk);
        @(negedge axi_clk);
        check_idle("t6_rst");
        @(posedge axi_clk);
        #1 axi_rstn = 1'b1;
        start_run(1'b0, 64'h5000, 64, 2);
        wait_done("t6b", 500);
        check_eq("t6b_bursts", n_bursts, 2);
        check_eq("t6b_error", o_error, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
